// File: rtl/retro_catc_multi.sv
`timescale 1ns/1ps
// retro_catc_multi: per-channel clock enables derived from an exact rational
// reference accumulator, with per-channel stall, catch-up debt and minimum tick spacing.
module retro_catc_multi #(
   parameter int unsigned           Channels       = 2,
   parameter int unsigned           CoreClock      = 200000000,
   parameter int unsigned           ReferenceClock = 21477272,
   parameter int unsigned           ClockFactor    = 2,
   parameter logic [8*Channels-1:0] ChannelDiv     = {8'd4, 8'd12},
   parameter int unsigned           DebtBits       = 16,
   parameter int unsigned           Lockstep       = 0
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         ClkEn,
   input  logic [Channels-1:0]          Delay,
   input  logic                         ClearOverflow,
   output logic [Channels-1:0]          ClkEnOut,
   output logic [Channels-1:0]          Behind,
   output logic [Channels-1:0]          Overflow,
   output logic [Channels*DebtBits-1:0] Debt
);
   localparam int unsigned     AccW  = $clog2(CoreClock) + 1;
   localparam logic [AccW-1:0] CoreK = AccW'(CoreClock);
   localparam logic [AccW-1:0] RefK  = AccW'(ReferenceClock);

   function automatic logic [63:0] min_gap(input int unsigned c);
      logic [63:0] g;
      g = (64'(ChannelDiv[8*c +: 8]) * 64'(CoreClock)) /
          (64'(ClockFactor) * 64'(ReferenceClock));
      return (g == 64'd0) ? 64'd1 : g;
   endfunction

   function automatic logic [63:0] max_gap();
      logic [63:0] m;
      m = 64'd1;
      for (int unsigned c = 0; c < Channels; c++)
         if (min_gap(c) > m) m = min_gap(c);
      return m;
   endfunction

   localparam int unsigned GapW = $clog2(max_gap() + 64'd1);

   function automatic logic [Channels*GapW-1:0] gap_vec();
      logic [Channels*GapW-1:0] v;
      v = '0;
      for (int unsigned c = 0; c < Channels; c++)
         v[GapW*c +: GapW] = GapW'(min_gap(c));
      return v;
   endfunction

   localparam logic [Channels*GapW-1:0] MinGapVec = gap_vec();

   logic [AccW-1:0]                     acc_q, acc_d, sum;
   logic                                ref_tick;
   logic [Channels-1:0][7:0]            presc_q, presc_d;
   logic [Channels-1:0][GapW-1:0]       gap_q, gap_d;
   logic [Channels-1:0][DebtBits-1:0]   debt_q, debt_d;
   logic [Channels-1:0]                 ovf_q, ovf_d;
   logic [Channels-1:0]                 ceo_q, ceo_d;
   logic [Channels-1:0]                 chan_tick;

   always_comb begin
      sum       = acc_q + RefK;
      ref_tick  = (sum >= CoreK);
      acc_d     = acc_q;
      presc_d   = presc_q;
      gap_d     = gap_q;
      debt_d    = debt_q;
      ovf_d     = ovf_q;
      chan_tick = '0;
      ceo_d     = '0;
      for (int unsigned c = 0; c < Channels; c++) begin
         chan_tick[c] = ref_tick && (presc_q[c] == ChannelDiv[8*c +: 8] - 8'd1);
         ceo_d[c]     = ClkEn && !(Delay[c] || (Lockstep != 0 && |Delay))
                        && (gap_q[c] >= MinGapVec[GapW*c +: GapW])
                        && (chan_tick[c] || debt_q[c] != '0);
      end
      if (ClkEn) begin
         acc_d = ref_tick ? sum - CoreK : sum;
         for (int unsigned c = 0; c < Channels; c++) begin
            if (ref_tick)
               presc_d[c] = chan_tick[c] ? 8'd0 : presc_q[c] + 8'd1;
            if (ceo_d[c])
               gap_d[c] = GapW'(1);
            else if (gap_q[c] < MinGapVec[GapW*c +: GapW])
               gap_d[c] = gap_q[c] + GapW'(1);
            // a natural tick that cannot go out now is owed; at full scale it is lost and flagged
            ovf_d[c] = ovf_q[c] && !ClearOverflow;
            if (chan_tick[c] && !ceo_d[c]) begin
               if (debt_q[c] == '1) ovf_d[c] = 1'b1;
               else                 debt_d[c] = debt_q[c] + DebtBits'(1);
            end else if (ceo_d[c] && !chan_tick[c]) begin
               debt_d[c] = debt_q[c] - DebtBits'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc_q   <= '0;
         presc_q <= '0;
         gap_q   <= MinGapVec;
         debt_q  <= '0;
         ovf_q   <= '0;
         ceo_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         presc_q <= presc_d;
         gap_q   <= gap_d;
         debt_q  <= debt_d;
         ovf_q   <= ovf_d;
         ceo_q   <= ceo_d;
      end
   end

   always_comb begin
      Behind = '0;
      for (int unsigned c = 0; c < Channels; c++) Behind[c] = |debt_q[c];
   end

   assign ClkEnOut = ceo_q;
   assign Overflow = ovf_q;
   assign Debt     = debt_q;
endmodule

// File: tb/tb_retro_catc_multi.sv
`timescale 1ns/1ps
// Scoreboard bench: two configurations share stimulus and are compared every cycle
// against a rational-arithmetic reference model, plus directed schedule checks.
module tb_retro_catc_multi;
   logic       clk = 1'b0;
   logic       Reset_n = 1'b0, ClkEn = 1'b0, ClearOverflow = 1'b0;
   logic [1:0] Delay = '0;
   logic [1:0] ceo_a, beh_a, ovf_a, ceo_b, beh_b, ovf_b;
   logic [3:0] debt_a;
   logic [7:0] debt_b;
   int         n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   retro_catc_multi #(.Channels(2), .CoreClock(10), .ReferenceClock(3), .ClockFactor(2),
      .ChannelDiv({8'd3, 8'd1}), .DebtBits(2), .Lockstep(0)) u_a (
      .Clk(clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .Delay(Delay), .ClearOverflow(ClearOverflow),
      .ClkEnOut(ceo_a), .Behind(beh_a), .Overflow(ovf_a), .Debt(debt_a));

   retro_catc_multi #(.Channels(2), .CoreClock(12), .ReferenceClock(3), .ClockFactor(2),
      .ChannelDiv({8'd2, 8'd1}), .DebtBits(4), .Lockstep(1)) u_b (
      .Clk(clk), .Reset_n(Reset_n), .ClkEn(ClkEn), .Delay(Delay), .ClearOverflow(ClearOverflow),
      .ClkEnOut(ceo_b), .Behind(beh_b), .Overflow(ovf_b), .Debt(debt_b));

   // reference model: tick k of the reference happens at the first enabled cycle n with floor(n*R/C) == k
   int unsigned m_core [2]    = '{10, 12};
   int unsigned m_ref  [2]    = '{3, 3};
   int unsigned m_div  [2][2] = '{'{1, 3}, '{1, 2}};
   int          m_dmax [2]    = '{3, 15};
   bit          m_lock [2]    = '{1'b0, 1'b1};
   longint      m_gap  [2][2];
   longint      m_n    [2];
   longint      m_last [2][2];
   int          m_debt [2][2];
   bit          m_ovf  [2][2];
   bit          m_ceo  [2][2];

   typedef struct {
      logic [1:0] ceo_a, beh_a, ovf_a;
      logic [3:0] debt_a;
      logic [1:0] ceo_b, beh_b, ovf_b;
      logic [7:0] debt_b;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int i, input logic rst, input logic en,
                             input logic [1:0] dly, input logic clr);
      longint t_now, t_prev;
      bit     ref_tick, ctick, stall, o;
      for (int c = 0; c < 2; c++) m_ceo[i][c] = 1'b0;
      if (!rst) begin
         m_n[i] = 0;
         for (int c = 0; c < 2; c++) begin
            m_last[i][c] = -1000000;
            m_debt[i][c] = 0;
            m_ovf[i][c]  = 1'b0;
         end
         return;
      end
      if (!en) return;
      m_n[i]++;
      t_now    = longint'(m_n[i] * m_ref[i] / m_core[i]);
      t_prev   = longint'((m_n[i] - 1) * m_ref[i] / m_core[i]);
      ref_tick = (t_now != t_prev);
      for (int c = 0; c < 2; c++) begin
         stall = dly[c] || (m_lock[i] && dly != 2'b00);
         ctick = ref_tick && (t_now % m_div[i][c] == 0);
         o     = !stall && (m_n[i] - m_last[i][c] >= m_gap[i][c]) && (ctick || m_debt[i][c] > 0);
         if (o) m_last[i][c] = m_n[i];
         m_ceo[i][c] = o;
         m_debt[i][c] = m_debt[i][c] + int'(ctick) - int'(o);
         if (m_debt[i][c] > m_dmax[i]) begin
            m_debt[i][c] = m_dmax[i];
            m_ovf[i][c]  = 1'b1;
         end else if (clr) begin
            m_ovf[i][c] = 1'b0;
         end
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic [1:0] dly, input logic clr);
      exp_t e;
      @(negedge clk);
      Reset_n = rst; ClkEn = en; Delay = dly; ClearOverflow = clr;
      model_step(0, rst, en, dly, clr);
      model_step(1, rst, en, dly, clr);
      e.ceo_a  = {m_ceo[0][1], m_ceo[0][0]};
      e.beh_a  = {m_debt[0][1] != 0, m_debt[0][0] != 0};
      e.ovf_a  = {m_ovf[0][1], m_ovf[0][0]};
      e.debt_a = {2'(m_debt[0][1]), 2'(m_debt[0][0])};
      e.ceo_b  = {m_ceo[1][1], m_ceo[1][0]};
      e.beh_b  = {m_debt[1][1] != 0, m_debt[1][0] != 0};
      e.ovf_b  = {m_ovf[1][1], m_ovf[1][0]};
      e.debt_b = {4'(m_debt[1][1]), 4'(m_debt[1][0])};
      sb_q.push_back(e);
      if (!rst) begin
         #1;
         check("rst_clkenout", {ceo_b, ceo_a}, 0);
         check("rst_debt", {debt_b, debt_a}, 0);
         check("rst_overflow", {ovf_b, ovf_a}, 0);
      end
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check("clkenout_a", ceo_a, mon_e.ceo_a);
         check("behind_a", beh_a, mon_e.beh_a);
         check("overflow_a", ovf_a, mon_e.ovf_a);
         check("debt_a", debt_a, mon_e.debt_a);
         check("clkenout_b", ceo_b, mon_e.ceo_b);
         check("behind_b", beh_b, mon_e.beh_b);
         check("overflow_b", ovf_b, mon_e.ovf_b);
         check("debt_b", debt_b, mon_e.debt_b);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      int     cnt, cnt1, k, first_a, first_b, peak, found;
      int     pos [6];
      int     exp_pos [6] = '{4, 7, 10, 14, 17, 20};
      logic [1:0] rd;
      for (int i = 0; i < 2; i++)
         for (int c = 0; c < 2; c++) begin
            m_gap[i][c] = longint'(m_div[i][c] * m_core[i] / (2 * m_ref[i]));
            if (m_gap[i][c] < 1) m_gap[i][c] = 1;
         end

      // exact ratio 3/10 on u_a channel 0
      repeat (3) step(1'b0, 1'b1, 2'b00, 1'b0);
      cnt = 0; k = 0;
      for (int cyc = 1; cyc <= 1000; cyc++) begin
         step(1'b1, 1'b1, 2'b00, 1'b0);
         if (ceo_a[0]) begin
            if (k < 6) pos[k] = cyc;
            k++; cnt++;
         end
      end
      check("ratio_count", cnt, 300);
      for (int i = 0; i < 6; i++) check("ratio_pulse_cycle", pos[i], exp_pos[i]);

      // catch-up on u_b channel 0 (MinGap 2), lockstep drags channel 1 along
      repeat (2) step(1'b0, 1'b1, 2'b00, 1'b0);
      cnt = 0; cnt1 = 0; peak = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         step(1'b1, 1'b1, (cyc >= 10 && cyc <= 21) ? 2'b01 : 2'b00, 1'b0);
         if (int'(debt_b[3:0]) > peak) peak = int'(debt_b[3:0]);
         if (cyc == 21) check("catchup_behind", beh_b[0], 1);
         cnt  += int'(ceo_b[0]);
         cnt1 += int'(ceo_b[1]);
      end
      check("catchup_peak_debt", peak, 3);
      check("catchup_count_ch0", cnt, 15);
      check("catchup_count_ch1", cnt1, 7);
      check("catchup_final_debt", debt_b, 0);

      // saturation on u_a channel 0 (2-bit debt)
      repeat (2) step(1'b0, 1'b1, 2'b00, 1'b0);
      for (int cyc = 1; cyc <= 45; cyc++) begin
         step(1'b1, 1'b1, (cyc >= 6) ? 2'b01 : 2'b00, cyc == 34);
         if (cyc == 34) check("sat_clear_during_delay", ovf_a[0], 1);
      end
      check("sat_debt", debt_a[1:0], 3);
      step(1'b1, 1'b1, 2'b00, 1'b0);
      step(1'b1, 1'b1, 2'b00, 1'b1);
      check("sat_clear_after_delay", ovf_a[0], 0);

      // ClkEn low mid-catch-up
      repeat (2) step(1'b0, 1'b1, 2'b00, 1'b0);
      for (int cyc = 1; cyc <= 26; cyc++) step(1'b1, 1'b1, (cyc >= 3) ? 2'b01 : 2'b00, 1'b0);
      repeat (2) step(1'b1, 1'b1, 2'b00, 1'b0);
      cnt = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         rd = 2'($urandom_range(0, 3));
         step(1'b1, 1'b0, rd, cyc == 5);
         cnt += int'(ceo_a[0]) + int'(ceo_a[1]) + int'(ceo_b[0]) + int'(ceo_b[1]);
      end
      check("freeze_pulses", cnt, 0);
      repeat (40) step(1'b1, 1'b1, 2'b00, 1'b0);

      // reset while u_b channel 0 owes 5 ticks
      repeat (2) step(1'b0, 1'b1, 2'b00, 1'b0);
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         step(1'b1, 1'b1, 2'b01, 1'b0);
         if (debt_b[3:0] == 4'd5) found = 1;
      end
      check("debt5_reached", found, 1);
      repeat (2) step(1'b0, 1'b1, 2'b00, 1'b0);
      first_a = 0; first_b = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         step(1'b1, 1'b1, 2'b00, 1'b0);
         if (ceo_a[0] && first_a == 0) first_a = cyc;
         if (ceo_b[0] && first_b == 0) first_b = cyc;
      end
      check("post_rst_first_a", first_a, 4);
      check("post_rst_first_b", first_b, 4);

      // randomized traffic with sticky stall patterns
      rd = 2'b00;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 15) == 0) rd = 2'($urandom_range(0, 3));
         step($urandom_range(0, 499) != 0, $urandom_range(0, 9) != 0, rd,
              $urandom_range(0, 19) == 0);
      end

      @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
